// File: rtl/ext_tid_alloc_ipa.sv
// ext_tid_alloc_ipa: transaction-ID allocator.
// Offers one free TID per cycle. Multiple release ports return TIDs to the
// free pool. Illegal releases set a sticky error flag and leave state unchanged.
module ext_tid_alloc_ipa #(
  parameter int EXT_TID_WIDTH   = 4,
  parameter int NB_OUTSND_TRANS = 2**EXT_TID_WIDTH,
  parameter int NB_REL_PORTS    = 2,
  parameter int ALLOC_MODE      = 0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  output logic                                    alloc_valid_o,
  output logic [EXT_TID_WIDTH-1:0]                alloc_tid_o,
  input  logic                                    alloc_ready_i,
  input  logic [NB_REL_PORTS-1:0]                 rel_valid_i,
  input  logic [NB_REL_PORTS*EXT_TID_WIDTH-1:0]   rel_tid_i,
  output logic [NB_OUTSND_TRANS-1:0]              busy_map_o,
  output logic [$clog2(NB_OUTSND_TRANS+1)-1:0]    outstanding_o,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic                                    rel_err_o,
  input  logic                                    clr_err_i
);

  localparam int W  = EXT_TID_WIDTH;
  localparam int NB = NB_OUTSND_TRANS;
  localparam int CW = $clog2(NB_OUTSND_TRANS+1);

  logic [NB-1:0] r_busy;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rr_ptr;
  logic          r_err;

  logic          w_full;
  logic          w_valid;
  logic          w_found;
  logic [W-1:0]  w_tid;
  int            w_start;

  logic [NB-1:0] w_clr;
  logic          w_ill;
  int            w_nrel;
  int            w_rel_idx;

  logic          w_alloc;
  logic [NB-1:0] w_alloc_mask;
  logic [NB-1:0] w_busy_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_rr_nxt;

  assign w_full  = (r_cnt == CW'(NB));
  assign w_valid = !w_full;

  // Pick the offered TID: first free slot at or above the start point, then wrap below it.
  always_comb begin
    w_found = 1'b0;
    w_tid   = '0;
    w_start = (ALLOC_MODE == 1) ? int'(r_rr_ptr) : 0;
    for (int i = 0; i < NB; i++) begin
      if (!w_found && i >= w_start && !r_busy[i]) begin
        w_found = 1'b1;
        w_tid   = W'(i);
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (!w_found && i < w_start && !r_busy[i]) begin
        w_found = 1'b1;
        w_tid   = W'(i);
      end
    end
  end

  // Classify each release port; a TID already cleared by a lower port counts as a duplicate.
  always_comb begin
    w_clr     = '0;
    w_ill     = 1'b0;
    w_nrel    = 0;
    w_rel_idx = 0;
    for (int p = 0; p < NB_REL_PORTS; p++) begin
      w_rel_idx = int'(rel_tid_i[p*W +: W]);
      if (rel_valid_i[p]) begin
        if (w_rel_idx >= NB) begin
          w_ill = 1'b1;
        end else if (!r_busy[w_rel_idx] || w_clr[w_rel_idx]) begin
          w_ill = 1'b1;
        end else begin
          w_clr[w_rel_idx] = 1'b1;
          w_nrel           = w_nrel + 1;
        end
      end
    end
  end

  // Combine allocation and releases into the next busy map, count and round-robin pointer.
  always_comb begin
    w_alloc      = w_valid & alloc_ready_i;
    w_alloc_mask = '0;
    w_rr_nxt     = r_rr_ptr;
    if (w_alloc) begin
      w_alloc_mask[w_tid] = 1'b1;
      w_rr_nxt = (int'(w_tid) + 1 >= NB) ? '0 : w_tid + 1'b1;
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_alloc_mask;
    w_cnt_nxt  = r_cnt + CW'(w_alloc) - CW'(w_nrel);
  end

  // State registers; reset discards every outstanding TID immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy   <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_nxt;
      if (w_ill) begin
        r_err <= 1'b1;
      end else if (clr_err_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign alloc_valid_o = w_valid;
  assign alloc_tid_o   = w_valid ? w_tid : '0;
  assign busy_map_o    = r_busy;
  assign outstanding_o = r_cnt;
  assign full_o        = w_full;
  assign empty_o       = (r_cnt == '0);
  assign rel_err_o     = r_err;

endmodule

// File: tb/tb_ext_tid_alloc_ipa.sv
// Bench for ext_tid_alloc_ipa: three instances (16 TIDs lowest-free, 16 TIDs
// round-robin, 12 TIDs lowest-free) checked against a behavioural model.
module tb_ext_tid_alloc_ipa;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]      ar = '0;
  logic [2:0]      ce = '0;
  logic [2:0][1:0] rv = '0;
  logic [2:0][7:0] rt = '0;

  logic d0_av, d1_av, d2_av;
  logic [3:0] d0_at, d1_at, d2_at;
  logic [15:0] d0_bm, d1_bm;
  logic [11:0] d2_bm;
  logic [4:0] d0_oc, d1_oc;
  logic [3:0] d2_oc;
  logic d0_fu, d1_fu, d2_fu, d0_em, d1_em, d2_em, d0_re, d1_re, d2_re;

  logic [2:0]       av, fu, em, re;
  logic [2:0][3:0]  at;
  logic [2:0][15:0] bm;
  logic [2:0][4:0]  oc;

  assign av = {d2_av, d1_av, d0_av};
  assign fu = {d2_fu, d1_fu, d0_fu};
  assign em = {d2_em, d1_em, d0_em};
  assign re = {d2_re, d1_re, d0_re};
  assign at = {d2_at, d1_at, d0_at};
  assign bm = {{4'b0, d2_bm}, d1_bm, d0_bm};
  assign oc = {{1'b0, d2_oc}, d1_oc, d0_oc};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_tid_alloc_ipa #(.EXT_TID_WIDTH(4), .NB_OUTSND_TRANS(16), .NB_REL_PORTS(2), .ALLOC_MODE(0)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(d0_av), .alloc_tid_o(d0_at),
    .alloc_ready_i(ar[0]), .rel_valid_i(rv[0]), .rel_tid_i(rt[0]), .busy_map_o(d0_bm),
    .outstanding_o(d0_oc), .full_o(d0_fu), .empty_o(d0_em), .rel_err_o(d0_re), .clr_err_i(ce[0]));

  ext_tid_alloc_ipa #(.EXT_TID_WIDTH(4), .NB_OUTSND_TRANS(16), .NB_REL_PORTS(2), .ALLOC_MODE(1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(d1_av), .alloc_tid_o(d1_at),
    .alloc_ready_i(ar[1]), .rel_valid_i(rv[1]), .rel_tid_i(rt[1]), .busy_map_o(d1_bm),
    .outstanding_o(d1_oc), .full_o(d1_fu), .empty_o(d1_em), .rel_err_o(d1_re), .clr_err_i(ce[1]));

  ext_tid_alloc_ipa #(.EXT_TID_WIDTH(4), .NB_OUTSND_TRANS(12), .NB_REL_PORTS(2), .ALLOC_MODE(0)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .alloc_valid_o(d2_av), .alloc_tid_o(d2_at),
    .alloc_ready_i(ar[2]), .rel_valid_i(rv[2]), .rel_tid_i(rt[2]), .busy_map_o(d2_bm),
    .outstanding_o(d2_oc), .full_o(d2_fu), .empty_o(d2_em), .rel_err_o(d2_re), .clr_err_i(ce[2]));

  // Behavioural model: set of busy TIDs, round-robin pointer, sticky error.
  bit [15:0] mb [3];
  int        mrr[3];
  bit        merr[3];

  function automatic int nb_of(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit rr_of(input int k);
    return (k == 1);
  endfunction

  function automatic int exp_offer(input int k);
    int start;
    int t;
    start = rr_of(k) ? mrr[k] : 0;
    for (int j = 0; j < nb_of(k); j++) begin
      t = (start + j) % nb_of(k);
      if (!mb[k][t]) return t;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mb[k] = '0; mrr[k] = 0; merr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int o;
        int t;
        bit ill;
        bit [15:0] nxt;
        bit [15:0] seen;
        o = exp_offer(k);
        nxt = mb[k];
        seen = '0;
        ill = 1'b0;
        for (int p = 0; p < 2; p++) begin
          if (rv[k][p]) begin
            t = int'(rt[k][p*4 +: 4]);
            if (t >= nb_of(k) || !mb[k][t] || seen[t]) ill = 1'b1;
            else nxt[t] = 1'b0;
            seen[t] = 1'b1;
          end
        end
        if (o >= 0 && ar[k]) begin
          nxt[o] = 1'b1;
          mrr[k] = (o + 1) % nb_of(k);
        end
        mb[k] = nxt;
        if (ill) merr[k] = 1'b1;
        else if (ce[k]) merr[k] = 1'b0;
      end
    end
  end

  // Every cycle out of reset, all outputs of every instance against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        int o;
        int n;
        o = exp_offer(k);
        n = $countones(mb[k]);
        chk($sformatf("d%0d_valid", k), 32'(av[k]), 32'(o >= 0));
        chk($sformatf("d%0d_tid", k),   32'(at[k]), (o < 0) ? 0 : o);
        chk($sformatf("d%0d_busy", k),  32'(bm[k]), 32'(mb[k]));
        chk($sformatf("d%0d_outst", k), 32'(oc[k]), n);
        chk($sformatf("d%0d_full", k),  32'(fu[k]), 32'(n == nb_of(k)));
        chk($sformatf("d%0d_empty", k), 32'(em[k]), 32'(n == 0));
        chk($sformatf("d%0d_err", k),   32'(re[k]), 32'(merr[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(av[0]), 1);
    chk("rst_tid",   32'(at[0]), 0);
    chk("rst_busy",  32'(bm[0]), 0);
    chk("rst_outst", 32'(oc[0]), 0);
    chk("rst_empty", 32'(em[0]), 1);
    chk("rst_full",  32'(fu[0]), 0);
    chk("rst_err",   32'(re[0]), 0);
    rst_n = 1'b1;

    // Lowest-free: 16 back-to-back allocations in order, then full.
    ar[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("d0_seq_tid", 32'(at[0]), i);
      step();
    end
    ar[0] = 1'b0;
    chk("d0_full_flag",  32'(fu[0]), 1);
    chk("d0_full_valid", 32'(av[0]), 0);
    chk("d0_full_outst", 32'(oc[0]), 16);

    // Release TID 5 from full: not offered in the release cycle, offered next.
    rv[0] = 2'b01; rt[0] = 8'h05;
    chk("d0_no_bypass", 32'(av[0]), 0);
    step();
    rv[0] = 2'b00;
    chk("d0_rel_valid", 32'(av[0]), 1);
    chk("d0_rel_tid",   32'(at[0]), 5);
    chk("d0_rel_outst", 32'(oc[0]), 15);

    // Round-robin: 0,1,2 then release 0 -> 3; allocate to 15 then wrap to 0.
    ar[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("d1_seq_tid", 32'(at[1]), i);
      step();
    end
    ar[1] = 1'b0;
    rv[1] = 2'b01; rt[1] = 8'h00;
    step();
    rv[1] = 2'b00;
    chk("d1_rr_next", 32'(at[1]), 3);
    ar[1] = 1'b1;
    for (int i = 3; i < 16; i++) begin
      chk("d1_rr_tid", 32'(at[1]), i);
      step();
    end
    ar[1] = 1'b0;
    chk("d1_wrap_tid",   32'(at[1]), 0);
    chk("d1_wrap_valid", 32'(av[1]), 1);

    // Same cycle: allocate 3 while ports release 1 and 2.
    ar[2] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rv[2] = 2'b11; rt[2] = {4'd2, 4'd1};
    chk("d2_pre_tid", 32'(at[2]), 3);
    step();
    ar[2] = 1'b0; rv[2] = 2'b00;
    chk("d2_mix_outst", 32'(oc[2]), 2);
    chk("d2_mix_busy",  32'(bm[2]), 32'h0009);
    chk("d2_mix_err",   32'(re[2]), 0);

    // Same TID on both ports: cleared once, error raised.
    rv[2] = 2'b11; rt[2] = {4'd3, 4'd3};
    step();
    rv[2] = 2'b00;
    chk("d2_dup_busy",  32'(bm[2]), 32'h0001);
    chk("d2_dup_outst", 32'(oc[2]), 1);
    chk("d2_dup_err",   32'(re[2]), 1);
    ce[2] = 1'b1; step(); ce[2] = 1'b0;
    chk("d2_clr_err", 32'(re[2]), 0);

    // Release of a free TID and of an out-of-range TID.
    rv[2] = 2'b01; rt[2] = 8'h07;
    step();
    rv[2] = 2'b00;
    chk("d2_free_err",  32'(re[2]), 1);
    chk("d2_free_busy", 32'(bm[2]), 32'h0001);
    ce[2] = 1'b1; step(); ce[2] = 1'b0;
    chk("d2_clr_err2", 32'(re[2]), 0);
    rv[2] = 2'b10; rt[2] = 8'hD0;
    step();
    rv[2] = 2'b00;
    chk("d2_range_err", 32'(re[2]), 1);
    ce[2] = 1'b1; rv[2] = 2'b01; rt[2] = 8'h0D;
    step();
    rv[2] = 2'b00;
    chk("d2_clr_vs_ill", 32'(re[2]), 1);
    step();
    ce[2] = 1'b0;
    chk("d2_clr_err3", 32'(re[2]), 0);

    // Fill the 12-TID instance; no TID 12..15 may ever be offered.
    ar[2] = 1'b1;
    for (int i = 1; i < 12; i++) begin
      chk("d2_fill_tid", 32'(at[2]), i);
      step();
    end
    ar[2] = 1'b0;
    chk("d2_full_flag",  32'(fu[2]), 1);
    chk("d2_full_valid", 32'(av[2]), 0);
    chk("d2_full_outst", 32'(oc[2]), 12);
    chk("d2_full_tid",   32'(at[2]), 0);

    // Bring d0 down to 8 outstanding by releasing 9..15, two per cycle.
    for (int t = 9; t <= 15; t += 2) begin
      rv[0] = (t < 15) ? 2'b11 : 2'b01;
      rt[0] = {4'(t + 1), 4'(t)};
      step();
    end
    rv[0] = 2'b00;
    chk("d0_eight_outst", 32'(oc[0]), 8);

    // Asynchronous reset pulse between clock edges.
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(av[0]), 1);
    chk("arst_tid",   32'(at[0]), 0);
    chk("arst_busy",  32'(bm[0]), 0);
    chk("arst_outst", 32'(oc[0]), 0);
    chk("arst_empty", 32'(em[0]), 1);
    chk("arst_full",  32'(fu[0]), 0);
    chk("arst_err",   32'(re[0]), 0);
    chk("arst_d2_busy", 32'(bm[2]), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_tid", 32'(at[0]), 0);
    ar[0] = 1'b1;
    step();
    ar[0] = 1'b0;
    chk("post_rst_busy", 32'(bm[0]), 32'h0001);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
